// File: rtl/opr1_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opr1_pkg : shared encodings for the Group 1 operate sequencer       |
// | Revision : 1.0                                                      |
// +--------------------------------------------------------------------+
package opr1_pkg;

  localparam logic [2:0] ROT_PASS = 3'b000;
  localparam logic [2:0] ROT_BSW  = 3'b001;
  localparam logic [2:0] ROT_RAL  = 3'b010;
  localparam logic [2:0] ROT_RTL  = 3'b011;
  localparam logic [2:0] ROT_RAR  = 3'b100;
  localparam logic [2:0] ROT_RTR  = 3'b101;

  localparam int IR_GRP = 8;
  localparam int IR_CLA = 7;
  localparam int IR_CLL = 6;
  localparam int IR_CMA = 5;
  localparam int IR_CML = 4;
  localparam int IR_RAR = 3;
  localparam int IR_RAL = 2;
  localparam int IR_BSW = 1;
  localparam int IR_IAC = 0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_CMP  = 3'd2,
    S_INC  = 3'd3,
    S_ROT  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  // First required step at or after position 'from' (0=CLR,1=CMP,2=INC,3=ROT).
  function automatic state_t next_step(input logic [7:0] f, input logic [1:0] from);
    state_t s;
    if ((from == 2'd0) && (f[IR_CLA] || f[IR_CLL]))
      s = S_CLR;
    else if ((from <= 2'd1) && (f[IR_CMA] || f[IR_CML]))
      s = S_CMP;
    else if ((from <= 2'd2) && f[IR_IAC])
      s = S_INC;
    else if (f[IR_RAR] || f[IR_RAL] || f[IR_BSW])
      s = S_ROT;
    else
      s = S_FIN;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/opr1_sequencer_rotsel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opr1_rotsel : decode of the {RAR,RAL,BSW} field to a rotater opcode |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module opr1_rotsel
  import opr1_pkg::*;
(
  input  logic [2:0] rot_field,
  output logic [2:0] rot_op
);

  // rot_field = {RAR, RAL, BSW/2x}; RAR+RAL together degrades to a pass.
  always_comb begin
    rot_op = ROT_PASS;
    case (rot_field)
      3'b001:  rot_op = ROT_BSW;
      3'b010:  rot_op = ROT_RAL;
      3'b011:  rot_op = ROT_RTL;
      3'b100:  rot_op = ROT_RAR;
      3'b101:  rot_op = ROT_RTR;
      default: rot_op = ROT_PASS;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/opr1_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | opr1_sequencer : multi-cycle PDP-8 Group 1 operate sequencer        |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module opr1_sequencer
  import opr1_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        START,
  input  logic [8:0]  IR,
  input  logic [11:0] AC_IN,
  input  logic        L_IN,
  output logic [11:0] AC_OUT,
  output logic        L_OUT,
  output logic        BUSY,
  output logic        DONE,
  output logic [2:0]  ROT_OP,
  output logic        ROT_OE,
  output logic [11:0] ROT_AI,
  output logic        ROT_LI,
  input  logic [11:0] ROT_AO,
  input  logic        ROT_LO
);

  state_t      state, state_nxt;
  logic [7:0]  fld;
  logic [11:0] ac;
  logic        l;
  logic [2:0]  rot_sel_op;
  logic [12:0] inc_sum;

  opr1_rotsel u_rotsel (
    .rot_field (fld[IR_RAR:IR_BSW]),
    .rot_op    (rot_sel_op)
  );

  assign inc_sum = {1'b0, ac} + 13'd1;
  assign AC_OUT  = ac;
  assign L_OUT   = l;
  assign ROT_AI  = ac;
  assign ROT_LI  = l;

  always_ff @(posedge CLK) begin
    if (!RESETn)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    ROT_OE    = 1'b0;
    ROT_OP    = ROT_PASS;
    case (state)
      S_IDLE: begin
        if (START)
          state_nxt = IR[IR_GRP] ? S_FIN : next_step(IR[7:0], 2'd0);
      end
      S_CLR: begin
        BUSY      = 1'b1;
        state_nxt = next_step(fld, 2'd1);
      end
      S_CMP: begin
        BUSY      = 1'b1;
        state_nxt = next_step(fld, 2'd2);
      end
      S_INC: begin
        BUSY      = 1'b1;
        state_nxt = next_step(fld, 2'd3);
      end
      S_ROT: begin
        BUSY      = 1'b1;
        ROT_OE    = 1'b1;
        ROT_OP    = rot_sel_op;
        state_nxt = S_FIN;
      end
      S_FIN: begin
        DONE      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      ac  <= 12'd0;
      l   <= 1'b0;
      fld <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START && !IR[IR_GRP]) begin
            fld <= IR[7:0];
            ac  <= AC_IN;
            l   <= L_IN;
          end
        end
        S_CLR: begin
          if (fld[IR_CLA]) ac <= 12'd0;
          if (fld[IR_CLL]) l  <= 1'b0;
        end
        S_CMP: begin
          if (fld[IR_CMA]) ac <= ~ac;
          if (fld[IR_CML]) l  <= ~l;
        end
        S_INC: begin
          // Carry out of bit 11 toggles the link rather than loading it.
          ac <= inc_sum[11:0];
          l  <= l ^ inc_sum[12];
        end
        S_ROT: begin
          ac <= ROT_AO;
          l  <= ROT_LO;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_opr1_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_opr1_sequencer : self-checking bench with rotater and ref model  |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_opr1_sequencer;

  logic        CLK = 1'b0;
  logic        RESETn, START, L_IN;
  logic [8:0]  IR;
  logic [11:0] AC_IN;
  logic [11:0] AC_OUT, ROT_AI, ROT_AO;
  logic        L_OUT, BUSY, DONE, ROT_OE, ROT_LI, ROT_LO;
  logic [2:0]  ROT_OP;
  logic [12:0] rv;

  int          total  = 0;
  int          passed = 0;
  logic [11:0] m_ac   = 12'd0;
  logic        m_l    = 1'b0;

  opr1_sequencer dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .START  (START),
    .IR     (IR),
    .AC_IN  (AC_IN),
    .L_IN   (L_IN),
    .AC_OUT (AC_OUT),
    .L_OUT  (L_OUT),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ROT_OP (ROT_OP),
    .ROT_OE (ROT_OE),
    .ROT_AI (ROT_AI),
    .ROT_LI (ROT_LI),
    .ROT_AO (ROT_AO),
    .ROT_LO (ROT_LO)
  );

  always #5 CLK = ~CLK;

  // Parent-level combinational rotater on the 13-bit {L,AC} word.
  always_comb begin
    rv = {ROT_LI, ROT_AI};
    case (ROT_OP)
      3'b001:  rv = {rv[12], rv[5:0], rv[11:6]};
      3'b010:  rv = {rv[11:0], rv[12]};
      3'b011:  rv = {rv[10:0], rv[12:11]};
      3'b100:  rv = {rv[0], rv[12:1]};
      3'b101:  rv = {rv[1:0], rv[12:2]};
      default: ;
    endcase
    ROT_AO = rv[11:0];
    ROT_LO = rv[12];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Architectural result of one Group 1 instruction.
  function automatic void model(input logic [8:0] ir, input logic [11:0] a, input logic li,
                                input logic [11:0] hold_a, input logic hold_l,
                                output logic [11:0] ra, output logic rl,
                                output int n, output logic [2:0] op);
    logic [11:0] x;
    logic        k;
    logic [12:0] s, v;
    n  = 0;
    op = 3'b000;
    if (ir[8]) begin
      ra = hold_a;
      rl = hold_l;
      return;
    end
    x = a;
    k = li;
    if (ir[7] || ir[6]) begin
      n++;
      if (ir[7]) x = 12'd0;
      if (ir[6]) k = 1'b0;
    end
    if (ir[5] || ir[4]) begin
      n++;
      if (ir[5]) x = ~x;
      if (ir[4]) k = ~k;
    end
    if (ir[0]) begin
      n++;
      s = {1'b0, x} + 13'd1;
      x = s[11:0];
      if (s[12]) k = ~k;
    end
    if (ir[3] || ir[2] || ir[1]) begin
      n++;
      v = {k, x};
      if (ir[3] && ir[2]) begin
        op = 3'b000;
      end else if (ir[2]) begin
        op = ir[1] ? 3'b011 : 3'b010;
        repeat (ir[1] ? 2 : 1) v = {v[11:0], v[12]};
      end else if (ir[3]) begin
        op = ir[1] ? 3'b101 : 3'b100;
        repeat (ir[1] ? 2 : 1) v = {v[0], v[12:1]};
      end else begin
        op = 3'b001;
        v  = {v[12], v[5:0], v[11:6]};
      end
      k = v[12];
      x = v[11:0];
    end
    ra = x;
    rl = k;
  endfunction

  task automatic run_op(input logic [8:0] ir, input logic [11:0] a, input logic li);
    logic [11:0] ea;
    logic        el;
    int          n, cyc, rotc;
    logic [2:0]  eop;
    bit          need_rot;
    model(ir, a, li, m_ac, m_l, ea, el, n, eop);
    need_rot = !ir[8] && (ir[3] || ir[2] || ir[1]);
    @(negedge CLK);
    START = 1'b1; IR = ir; AC_IN = a; L_IN = li;
    @(negedge CLK);
    START = 1'b0; AC_IN = 12'($urandom); L_IN = 1'($urandom);
    cyc  = 1;
    rotc = 0;
    while (DONE !== 1'b1 && cyc <= 8) begin
      check("step_busy", 32'(BUSY), 32'd1);
      if (ROT_OE === 1'b1) begin
        rotc++;
        check("rot_op", 32'(ROT_OP), 32'(eop));
      end else begin
        check("rot_op_off", 32'(ROT_OP), 32'd0);
      end
      @(negedge CLK);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(n + 1));
    check("ac_out", 32'(AC_OUT), 32'(ea));
    check("l_out", 32'(L_OUT), 32'(el));
    check("fin_busy", 32'(BUSY), 32'd0);
    check("rot_cycles", 32'(rotc), 32'(need_rot));
    m_ac = ea;
    m_l  = el;
    @(negedge CLK);
    check("idle_done", 32'(DONE), 32'd0);
    check("idle_busy", 32'(BUSY), 32'd0);
    check("hold_ac", 32'(AC_OUT), 32'(ea));
  endtask

  initial begin
    logic [8:0] rir;
    RESETn = 1'b0; START = 1'b0; IR = 9'd0; AC_IN = 12'd0; L_IN = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_ac", 32'(AC_OUT), 32'd0);
    check("rst_l", 32'(L_OUT), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_oe", 32'(ROT_OE), 32'd0);
    check("rst_op", 32'(ROT_OP), 32'd0);
    RESETn = 1'b1;

    run_op(9'o341, 12'o1234, 1'b1);  // CLA CLL CMA IAC
    run_op(9'o006, 12'o4001, 1'b0);  // RTL
    run_op(9'o010, 12'o0001, 1'b0);  // RAR
    run_op(9'o002, 12'o0077, 1'b1);  // BSW
    run_op(9'o014, 12'o5252, 1'b1);  // RAR+RAL
    run_op(9'o000, 12'o3333, 1'b0);  // no-op
    run_op(9'o400, 12'o7070, 1'b1);  // not Group 1: hold
    run_op(9'o221, 12'o7777, 1'b0);  // CLA CML IAC
    run_op(9'o012, 12'o0003, 1'b1);  // RTR

    // START held high through FIN: second op only after the IDLE cycle.
    @(negedge CLK);
    START = 1'b1; IR = 9'o002; AC_IN = 12'o0077; L_IN = 1'b0;
    @(negedge CLK);
    check("hold_rot_busy", 32'(BUSY), 32'd1);
    check("hold_rot_op", 32'(ROT_OP), 32'd1);
    @(negedge CLK);
    check("hold_fin_done", 32'(DONE), 32'd1);
    check("hold_fin_ac", 32'(AC_OUT), 32'o7700);
    @(negedge CLK);
    check("hold_idle_done", 32'(DONE), 32'd0);
    check("hold_idle_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    START = 1'b0;
    check("hold_second_busy", 32'(BUSY), 32'd1);
    @(negedge CLK);
    check("hold_second_done", 32'(DONE), 32'd1);
    check("hold_second_ac", 32'(AC_OUT), 32'o7700);
    @(negedge CLK);
    m_ac = 12'o7700;
    m_l  = 1'b0;

    // Reset during the INC step of CLA CLL CMA IAC.
    @(negedge CLK);
    START = 1'b1; IR = 9'o341; AC_IN = 12'o1234; L_IN = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_inc_busy", 32'(BUSY), 32'd1);
    RESETn = 1'b0;
    @(negedge CLK);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    check("abort_ac", 32'(AC_OUT), 32'd0);
    check("abort_l", 32'(L_OUT), 32'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    check("abort_no_done", 32'(DONE), 32'd0);
    check("abort_idle", 32'(BUSY), 32'd0);
    m_ac = 12'd0;
    m_l  = 1'b0;

    for (int i = 0; i < 40; i++) begin
      rir = 9'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) rir[8] = 1'b0;
      run_op(rir, 12'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
